// File: rtl/mealy_overlapping_101111.sv
// mealy_overlapping_101111
//
// Serial Mealy detector for the pattern 1-0-1-1-1-1 (first bit received
// first), with overlapping matches. One bit of x is consumed per rising
// edge of clk. z is combinational from the current state and the current x,
// so it is high in the same cycle that x carries the final pattern bit.
//
// Optional feature: define MEALY_101111_CNT_EN to add match_cnt, an 8-bit
// saturating count of detections.
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   x          in   serial data bit
//   z          out  detect flag, high when the current x completes the pattern
//   match_cnt  out  [7:0] saturating detection count (MEALY_101111_CNT_EN only)

module mealy_overlapping_101111 (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
`ifdef MEALY_101111_CNT_EN
    output logic [7:0] match_cnt,
`endif
    output logic       z
);

    // Each state names the longest received suffix that is a pattern prefix.
    typedef enum logic [2:0] {
        StNone   = 3'd0,  // ""
        St1      = 3'd1,  // "1"
        St10     = 3'd2,  // "10"
        St101    = 3'd3,  // "101"
        St1011   = 3'd4,  // "1011"
        St10111  = 3'd5   // "10111"
    } state_e;

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StNone;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StNone;
        z       = 1'b0;
        case (state_q)
            StNone:  state_d = x ? St1 : StNone;
            St1:     state_d = x ? St1 : St10;
            St10:    state_d = x ? St101 : StNone;
            St101:   state_d = x ? St1011 : St10;
            St1011:  state_d = x ? St10111 : St10;
            St10111: begin
                // The completing 1 is itself the prefix "1" of the next match.
                state_d = x ? St1 : St10;
                z       = x;
            end
            // Encodings 6 and 7 fall back to the idle state with z low.
            default: state_d = StNone;
        endcase
        if (rst) begin
            z = 1'b0;
        end
    end

`ifdef MEALY_101111_CNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if (z && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mealy_overlapping_101111.sv
// Testbench for mealy_overlapping_101111.
// Expected z values come from a reference model that compares the last six
// consumed-or-presented bits against 101111; they are queued when each bit is
// driven and popped when z is sampled. The counter model is checked when
// MEALY_101111_CNT_EN is defined.

module tb_mealy_overlapping_101111;

    logic clk;
    logic rst;
    logic x;
    logic z;
`ifdef MEALY_101111_CNT_EN
    logic [7:0] match_cnt;
`endif

    int unsigned n_cmp;
    int unsigned n_bad;

    // Reference model state: bits consumed since the last reset.
    logic [4:0]  hist;
    int unsigned hist_len;
    int unsigned cnt_model;

    logic exp_q[$];

    mealy_overlapping_101111 dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
`ifdef MEALY_101111_CNT_EN
        .match_cnt (match_cnt),
`endif
        .z         (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle: present b with reset r, check z before the edge,
    // then advance the reference model as the edge consumes the bit.
    task automatic drive_bit(input string tag, input logic b, input logic r);
        logic e;
        logic got;
        @(negedge clk);
        x   = b;
        rst = r;
        e   = !r && (hist_len >= 5) && ({hist, b} == 6'b101111);
        exp_q.push_back(e);
        #1;
`ifdef MEALY_101111_CNT_EN
        if (hist_len != 0 || r) begin
            check_eq({tag, "_cnt"}, {24'd0, match_cnt}, cnt_model);
        end
`endif
        got = exp_q.pop_front();
        check_eq(tag, {31'd0, z}, {31'd0, got});
        if (r) begin
            hist      = 5'd0;
            hist_len  = 0;
            cnt_model = 0;
        end else begin
            hist = {hist[3:0], b};
            if (hist_len < 5) hist_len++;
            if (e && cnt_model < 255) cnt_model++;
            if (hist_len == 0) hist_len = 0;
        end
    endtask

    task automatic drive_seq(input string tag, input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            drive_bit(tag, bits[i], 1'b0);
        end
    endtask

    task automatic do_reset(input string tag);
        drive_bit(tag, 1'b1, 1'b1);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        hist      = 5'd0;
        hist_len  = 0;
        cnt_model = 0;
        rst       = 1'b1;
        x         = 1'b0;

        // Reset state, z held low while reset is high even with x=1.
        drive_bit("rst_z0", 1'b0, 1'b1);
        drive_bit("rst_z1", 1'b1, 1'b1);

        // 1,1,0,1,1,1,1 then a trailing 0.
        drive_seq("t1", 32'b11011110, 8);

        // Leading zeros and the 10 restart.
        do_reset("t2_rst");
        drive_seq("t2", 32'b00101111, 8);

        // Overlapping detections on bits 6 and 11.
        do_reset("t3_rst");
        drive_seq("t3", 32'b10111101111, 11);
`ifdef MEALY_101111_CNT_EN
        @(negedge clk);
        #1;
        check_eq("t3_cnt2", {24'd0, match_cnt}, 32'd2);
`endif

        // Near misses.
        do_reset("t4_rst");
        drive_seq("t4a", 32'b1011101111, 10);
        do_reset("t4b_rst");
        drive_seq("t4b", 32'b1001111, 7);

        // Reset mid-pattern, presented with x=1 while in state "10111".
        do_reset("t5_rst0");
        drive_seq("t5a", 32'b10111, 5);
        drive_bit("t5_midrst", 1'b1, 1'b1);
        drive_seq("t5b", 32'b1101111, 7);

        // Random stream with occasional resets.
        for (int i = 0; i < 400; i++) begin
            drive_bit("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
        end

`ifdef MEALY_101111_CNT_EN
        // Counter saturation, then reset clears it.
        do_reset("t6_rst");
        for (int i = 0; i < 300; i++) begin
            drive_seq("t6", 32'b101111, 6);
        end
        @(negedge clk);
        #1;
        check_eq("t6_sat", {24'd0, match_cnt}, 32'd255);
        do_reset("t6_rst2");
        @(negedge clk);
        #1;
        check_eq("t6_clr", {24'd0, match_cnt}, 32'd0);
`endif

        check_eq("sb_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
